// File: rtl/bus_timer_pkg.sv
// Shared constants for the memory-mapped bus timer: register offsets,
// TCON bit positions, reset values and the timer state type.
package bus_timer_pkg;

  localparam logic [31:0] OFF_TH   = 32'h0000_0000;
  localparam logic [31:0] OFF_TL   = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON = 32'h0000_0008;
  localparam logic [31:0] OFF_PRE  = 32'h0000_000C;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IF = 2;
  localparam int TCON_OS = 3;

  localparam logic [31:0] TH_RST   = 32'h0000_0000;
  localparam logic [31:0] TL_RST   = 32'h0000_0000;
  localparam logic [3:0]  TCON_RST = 4'h0;
  localparam logic [7:0]  PRE_RST  = 8'h00;

  localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_TH   = 3'd1,
    SEL_TL   = 3'd2,
    SEL_TCON = 3'd3,
    SEL_PRE  = 3'd4
  } sel_e;

  // Full 32-bit compare; anything outside the four word slots is not ours.
  function automatic sel_e decode_reg(input logic [31:0] addr, input logic [31:0] base);
    sel_e sel;
    sel = SEL_NONE;
    if (addr == base + OFF_TH)        sel = SEL_TH;
    else if (addr == base + OFF_TL)   sel = SEL_TL;
    else if (addr == base + OFF_TCON) sel = SEL_TCON;
    else if (addr == base + OFF_PRE)  sel = SEL_PRE;
    return sel;
  endfunction

endpackage

// File: rtl/bus_timer_if.sv
// CPU-side register bus seen by the timer; rdata is OR-combined with other
// responders so it must be zero whenever the timer is not selected for a read.
interface bus_timer_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irqout;

  modport master (output rd, output wr, output addr, output wdata,
                  input rdata, input irqout);
  modport slave  (input rd, input wr, input addr, input wdata,
                  output rdata, output irqout);
endinterface

// File: rtl/bus_timer_prescaler.sv
// Tick generator: one tick every PRE+1 clocks while running.
// Only present when BUS_TIMER_PRESCALE_EN is defined.
`ifdef BUS_TIMER_PRESCALE_EN
module bus_timer_prescaler
  import bus_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run,
  input  logic       i_pre_wr,
  input  logic [7:0] i_pre,
  output logic       o_tick
);

  logic [7:0] r_cnt;

  assign o_tick = i_run && (r_cnt == i_pre);

  // Restart the divide sequence whenever the timer stops or PRE changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= PRE_RST;
    end else if (i_pre_wr || !i_run || o_tick) begin
      r_cnt <= 8'h00;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/bus_timer.sv
// Memory-mapped up-counting timer with reload, one-shot mode and a level IRQ.
// Define BUS_TIMER_PRESCALE_EN to add the PRE register and tick prescaler.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h4000_0020
) (
  input  logic       clk,
  input  logic       reset,
  bus_timer_if.slave bus
);

  sel_e        w_sel;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;
  logic        w_run;
  logic        w_tick;
  logic        w_ovf;
  logic [31:0] w_tcon;
  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic        r_ie;
  logic        r_if;
  logic        r_os;
  logic        r_irq;

  assign w_sel     = decode_reg(bus.addr, BASE);
  assign w_wr_th   = bus.wr && (w_sel == SEL_TH);
  assign w_wr_tl   = bus.wr && (w_sel == SEL_TL);
  assign w_wr_tcon = bus.wr && (w_sel == SEL_TCON);
  assign w_run     = (r_state == ST_RUN);
  assign w_ovf     = w_tick && (r_tl == TL_MAX);

`ifdef BUS_TIMER_PRESCALE_EN
  logic [7:0] r_pre;
  logic       w_wr_pre;

  assign w_wr_pre = bus.wr && (w_sel == SEL_PRE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= PRE_RST;
    end else if (w_wr_pre) begin
      r_pre <= bus.wdata[7:0];
    end
  end

  bus_timer_prescaler u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .i_run    (w_run),
    .i_pre_wr (w_wr_pre),
    .i_pre    (r_pre),
    .o_tick   (w_tick)
  );
`else
  assign w_tick = w_run;
`endif

  // The state register doubles as TCON.EN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A software TCON write decides EN outright, even against a one-shot stop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_tcon && bus.wdata[TCON_EN]) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_wr_tcon) begin
          w_state_nxt = bus.wdata[TCON_EN] ? ST_RUN : ST_IDLE;
        end else if (w_ovf && r_os) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th  <= TH_RST;
      r_tl  <= TL_RST;
      r_ie  <= TCON_RST[TCON_IE];
      r_if  <= TCON_RST[TCON_IF];
      r_os  <= TCON_RST[TCON_OS];
      r_irq <= 1'b0;
    end else begin
      if (w_wr_th) r_th <= bus.wdata;

      if (w_wr_tl) begin
        r_tl <= bus.wdata;
      end else if (w_tick) begin
        r_tl <= w_ovf ? r_th : r_tl + 32'd1;
      end

      if (w_wr_tcon) begin
        r_ie <= bus.wdata[TCON_IE];
        r_os <= bus.wdata[TCON_OS];
      end

      // Hardware set beats a software clear so no interrupt is dropped.
      if (w_ovf) begin
        r_if <= 1'b1;
      end else if (w_wr_tcon && !bus.wdata[TCON_IF]) begin
        r_if <= 1'b0;
      end

      r_irq <= r_ie & r_if;
    end
  end

  always_comb begin
    w_tcon          = 32'h0;
    w_tcon[TCON_EN] = w_run;
    w_tcon[TCON_IE] = r_ie;
    w_tcon[TCON_IF] = r_if;
    w_tcon[TCON_OS] = r_os;
  end

  always_comb begin
    bus.rdata = 32'h0;
    if (bus.rd) begin
      case (w_sel)
        SEL_TH:   bus.rdata = r_th;
        SEL_TL:   bus.rdata = r_tl;
        SEL_TCON: bus.rdata = w_tcon;
`ifdef BUS_TIMER_PRESCALE_EN
        SEL_PRE:  bus.rdata = {24'h0, r_pre};
`else
        SEL_PRE:  bus.rdata = 32'h0;
`endif
        default:  bus.rdata = 32'h0;
      endcase
    end
  end

  assign bus.irqout = r_irq;

endmodule
